// File: rtl/fetch_unit_pkg.sv
// Types and constants shared by the fetch stage, its output FIFO and the
// fetch->decode skid-buffer port.
package fetch_unit_pkg;

    localparam int unsigned INSTRUCTION_BYTES = 4;

    typedef struct packed {
        logic [31:0] instruction;
        logic [31:0] pc;
    } fetch_packet;

    typedef enum logic {
        FETCH_RUN   = 1'b0,
        FETCH_FAULT = 1'b1
    } fetch_state;

endpackage

// File: rtl/fetch_unit_if.sv
// Valid/ready skid-buffer handshake carrying a fetched instruction and its pc.
// The downstream modport is the producer end handing packets further down the pipe.
interface skid_buffer_port;
    import fetch_unit_pkg::*;

    logic        valid;
    logic        ready;
    fetch_packet data;

    modport downstream (output valid, output data, input ready);
    modport upstream   (input valid, input data, output ready);

endinterface

// File: rtl/fetch_unit_fifo.sv
// Two-entry synchronous FIFO holding fetched packets until decode takes them.
// Flush wins over push/pop; a push while full is accepted only alongside a pop.
module fetch_fifo
    import fetch_unit_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        push,
    input  fetch_packet push_data,
    input  logic        pop,
    input  logic        flush,
    output logic [1:0]  count,
    output fetch_packet head,
    output logic        empty,
    output logic        full
);

    fetch_packet entries [2];
    logic        rd_ptr;
    logic        wr_ptr;
    logic        do_push;
    logic        do_pop;

    always_comb begin
        empty   = (count == 2'd0);
        full    = (count == 2'd2);
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        head    = entries[rd_ptr];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) wr_ptr <= ~wr_ptr;
            if (do_pop)  rd_ptr <= ~rd_ptr;
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage needs no reset: count gates every read.
    always_ff @(posedge clock) begin
        if (do_push && !flush) entries[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the pc, keeps one word read in flight and
// buffers returned words for decode; redirects flush, errors latch a sticky fault.
//
//   state       | meaning
//   FETCH_RUN   | fetching normally
//   FETCH_FAULT | no new requests; buffered words drain, late responses dropped
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic                       clock,
    input  logic                       reset,
    output logic                       mem_req_valid,
    input  logic                       mem_req_ready,
    output logic [31:0]                mem_req_addr,
    input  logic                       mem_resp_valid,
    input  logic [31:0]                mem_resp_data,
    input  logic                       mem_resp_error,
    input  logic                       redirect_valid,
    input  logic [31:0]                redirect_target,
    skid_buffer_port.downstream        to_decode,
    output logic                       fault,
    output logic [31:0]                fault_pc
);

    fetch_state  state;
    fetch_state  state_next;
    logic [31:0] pc;
    logic [31:0] req_pc;
    logic        outstanding;
    logic        discard;
    logic        live;

    logic        resp_fire;
    logic        req_fire;
    logic        pop;
    logic        push;
    logic        resp_faults;
    logic        misaligned;
    logic [2:0]  used_slots;
    fetch_packet push_packet;
    logic [1:0]  fifo_count;
    fetch_packet fifo_head;
    logic        fifo_empty;
    logic        fifo_full;

    always_comb begin
        resp_fire   = mem_resp_valid && outstanding;
        pop         = to_decode.valid && to_decode.ready;
        misaligned  = (redirect_target[1:0] != 2'b00);
        resp_faults = resp_fire && !discard && mem_resp_error && (state == FETCH_RUN);
        // Every in-flight read owns a FIFO slot; a same-cycle pop frees one.
        used_slots  = {1'b0, fifo_count} + {2'b00, outstanding} - {2'b00, pop};

        mem_req_valid = live
                     && (state == FETCH_RUN)
                     && !redirect_valid
                     && (!outstanding || mem_resp_valid)
                     && (used_slots <= 3'(FIFO_DEPTH - 1));
        mem_req_addr  = pc;
        req_fire      = mem_req_valid && mem_req_ready;

        push = resp_fire && !redirect_valid && !discard && !mem_resp_error
            && (state == FETCH_RUN) && (!fifo_full || pop);
        push_packet.instruction = mem_resp_data;
        push_packet.pc          = req_pc;
    end

    always_comb begin
        state_next = state;
        case (state)
            FETCH_RUN: begin
                if (redirect_valid) begin
                    if (misaligned) state_next = FETCH_FAULT;
                end else if (resp_faults) begin
                    state_next = FETCH_FAULT;
                end
            end
            FETCH_FAULT: state_next = FETCH_FAULT;
            default:     state_next = FETCH_FAULT;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= FETCH_RUN;
            pc          <= RESET_PC;
            req_pc      <= 32'h0;
            outstanding <= 1'b0;
            discard     <= 1'b0;
            fault_pc    <= 32'h0;
            live        <= 1'b0;
        end else begin
            live  <= 1'b1;
            state <= state_next;
            if (redirect_valid) begin
                // A response landing in the redirect cycle is consumed here;
                // one still pending must be dropped when it arrives.
                outstanding <= outstanding && !mem_resp_valid;
                discard     <= outstanding && !mem_resp_valid;
                if (state == FETCH_RUN) begin
                    pc <= redirect_target;
                    if (misaligned) fault_pc <= redirect_target;
                end
            end else begin
                if (req_fire) begin
                    req_pc      <= pc;
                    pc          <= pc + 32'(INSTRUCTION_BYTES);
                    outstanding <= 1'b1;
                end else if (resp_fire) begin
                    outstanding <= 1'b0;
                end
                if (resp_fire && discard) discard <= 1'b0;
                if (resp_faults) fault_pc <= req_pc;
            end
        end
    end

    fetch_fifo u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (push_packet),
        .pop       (pop),
        .flush     (redirect_valid),
        .count     (fifo_count),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign to_decode.valid = !fifo_empty;
    assign to_decode.data  = fifo_head;
    assign fault           = (state == FETCH_FAULT);

endmodule
